vga_color_tracker: RTL and testbench



---
 rtl/vga_probe_pkg.sv | 28 ++
 rtl/vga_sync_edge.sv | 36 +++
 rtl/vga_color_tracker.sv | 240 ++++++++++++++++++++++++
 tb/tb_vga_color_tracker.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_probe_pkg.sv
// vga_probe_pkg
//   Definitions shared by the XVGA probe logic: tracker FSM encoding, datapath
//   widths, and the colours the display pipeline paints its blobs with.
//   Ports: none (package).
package vga_probe_pkg;

  localparam int X_W   = 11;
  localparam int Y_W   = 10;
  localparam int CNT_W = 20;
  localparam int SUM_W = 30;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    VSYNC      = 2'd1,
    ACCUM      = 2'd2
  } tracker_state_t;

  localparam logic [23:0] COLOR_ROVER    = 24'hFF_00_00;
  localparam logic [23:0] COLOR_TARGET   = 24'h00_FF_00;
  localparam logic [23:0] COLOR_ORIENTED = 24'h00_00_FF;

  function automatic logic color_match(input logic [23:0] pix,
                                       input logic [23:0] color,
                                       input logic [23:0] mask);
    return (pix & mask) == (color & mask);
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge
//   Double-registers one raster control signal and produces registered
//   one-cycle rise/fall pulses that line up with the second register stage.
//   Ports:
//     vclock  in   pixel clock
//     reset   in   asynchronous, active-high
//     d       in   raw signal from the display pipeline
//     q       out  signal after two register stages
//     rise    out  1 on the first cycle q reads 1 after reading 0
//     fall    out  1 on the first cycle q reads 0 after reading 1
module vga_sync_edge (
  input  logic vclock,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic s1;

  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      s1   <= 1'b0;
      q    <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= d;
      q    <= s1;
      rise <= s1 & ~q;
      fall <= ~s1 & q;
    end
  end

endmodule

// File: rtl/vga_color_tracker.sv
// vga_color_tracker
//   Rebuilds raster coordinates from the delayed XVGA sync/blank stream and
//   reports, once per frame, the bounding box and number of pixels matching
//   MATCH_COLOR under MATCH_MASK.
//   Optional build macro: TRACKER_SUMS_EN adds sum_x/sum_y (centroid sums).
//   Ports:
//     vclock        in   65 MHz pixel clock
//     reset         in   asynchronous, active-high
//     phsync/pvsync in   sync, active low
//     pblank        in   1 = blanking interval
//     pixel         in   24-bit colour (r=23:16, g=15:8, b=7:0)
//     frame_ack     in   consumer has taken the result
//     frame_valid   out  result registers hold a completed frame
//     found         out  published match_count != 0
//     min_x/max_x   out  bounding box x (0 = left)
//     min_y/max_y   out  bounding box y (0 = top)
//     match_count   out  matching pixels in the frame (saturating)
//     sync_error    out  sticky; line or frame length mismatch
//     overrun       out  sticky; unacknowledged result overwritten
//     sum_x/sum_y   out  (TRACKER_SUMS_EN) coordinate sums of matching pixels
//
//   state      | meaning
//   WAIT_FRAME | after reset, discarding the partial frame in flight
//   VSYNC      | inside vertical sync, waiting for its end
//   ACCUM      | accumulating the current frame until the next vsync
module vga_color_tracker
  import vga_probe_pkg::*;
#(
  parameter int          H_ACTIVE    = 1024,
  parameter int          V_ACTIVE    = 768,
  parameter logic [23:0] MATCH_COLOR = COLOR_ROVER,
  parameter logic [23:0] MATCH_MASK  = 24'hFF_FF_FF
) (
  input  logic             vclock,
  input  logic             reset,
  input  logic             phsync,
  input  logic             pvsync,
  input  logic             pblank,
  input  logic [23:0]      pixel,
  input  logic             frame_ack,
  output logic             frame_valid,
  output logic             found,
  output logic [X_W-1:0]   min_x,
  output logic [X_W-1:0]   max_x,
  output logic [Y_W-1:0]   min_y,
  output logic [Y_W-1:0]   max_y,
  output logic [CNT_W-1:0] match_count,
  output logic             sync_error,
  output logic             overrun
`ifdef TRACKER_SUMS_EN
  ,
  output logic [SUM_W-1:0] sum_x,
  output logic [SUM_W-1:0] sum_y
`endif
);

  logic hs_q, hs_rise, hs_fall;
  logic vs_q, vs_rise, vs_fall;
  logic blank_q, blank_rise, blank_fall;
  logic [23:0] pix_s1, pix_s2;

  vga_sync_edge u_hsync (.vclock(vclock), .reset(reset), .d(phsync),
                         .q(hs_q), .rise(hs_rise), .fall(hs_fall));
  vga_sync_edge u_vsync (.vclock(vclock), .reset(reset), .d(pvsync),
                         .q(vs_q), .rise(vs_rise), .fall(vs_fall));
  vga_sync_edge u_blank (.vclock(vclock), .reset(reset), .d(pblank),
                         .q(blank_q), .rise(blank_rise), .fall(blank_fall));

  // Coordinates come from blank alone; hsync and the vsync level are carried
  // along only so all three controls see identical pipeline delay.
  logic unused_sync;
  assign unused_sync = ^{hs_q, hs_rise, hs_fall, vs_q};

  // Pixel delayed by the same two stages as the control pulses.
  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      pix_s1 <= '0;
      pix_s2 <= '0;
    end else begin
      pix_s1 <= pixel;
      pix_s2 <= pix_s1;
    end
  end

  tracker_state_t state_q, state_d;
  logic start_frame, publish;

  always_ff @(posedge vclock or posedge reset) begin
    if (reset) state_q <= WAIT_FRAME;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    publish     = 1'b0;
    case (state_q)
      WAIT_FRAME: if (vs_fall) state_d = VSYNC;
      VSYNC: if (vs_rise) begin
        state_d     = ACCUM;
        start_frame = 1'b1;
      end
      ACCUM: if (vs_fall) begin
        state_d = VSYNC;
        publish = 1'b1;
      end
      default: state_d = WAIT_FRAME;
    endcase
  end

  logic [X_W-1:0] x_cnt, x_use;
  logic [Y_W-1:0] y_cnt, y_inc, y_chk;
  logic           eol, hit;

  // First active cycle of a line is x=0 regardless of the counter's history.
  assign x_use = blank_fall ? '0 : x_cnt;
  assign eol   = blank_rise;
  assign y_inc = (y_cnt == '1) ? y_cnt : y_cnt + 1'b1;
  // A line ending in the publish cycle is counted before the frame check.
  assign y_chk = eol ? y_inc : y_cnt;
  assign hit   = (state_q == ACCUM) && !blank_q &&
                 color_match(pix_s2, MATCH_COLOR, MATCH_MASK);

  logic [CNT_W-1:0] acc_cnt, cnt_d;
  logic [X_W-1:0]   acc_min_x, acc_max_x, min_x_d, max_x_d;
  logic [Y_W-1:0]   acc_min_y, acc_max_y, min_y_d, max_y_d;
  logic             any_d;
`ifdef TRACKER_SUMS_EN
  logic [SUM_W-1:0] acc_sum_x, acc_sum_y, sum_x_d, sum_y_d;
`endif

  // Next accumulator values; the publish path takes these so a match in the
  // publish cycle itself is not lost.
  always_comb begin
    cnt_d   = acc_cnt;
    min_x_d = acc_min_x;
    max_x_d = acc_max_x;
    min_y_d = acc_min_y;
    max_y_d = acc_max_y;
`ifdef TRACKER_SUMS_EN
    sum_x_d = acc_sum_x;
    sum_y_d = acc_sum_y;
`endif
    if (hit) begin
      if (acc_cnt != '1) cnt_d = acc_cnt + 1'b1;
      if (x_use < acc_min_x) min_x_d = x_use;
      if (x_use > acc_max_x) max_x_d = x_use;
      if (y_cnt < acc_min_y) min_y_d = y_cnt;
      if (y_cnt > acc_max_y) max_y_d = y_cnt;
`ifdef TRACKER_SUMS_EN
      sum_x_d = acc_sum_x + {{(SUM_W-X_W){1'b0}}, x_use};
      sum_y_d = acc_sum_y + {{(SUM_W-Y_W){1'b0}}, y_cnt};
`endif
    end
  end

  assign any_d = (cnt_d != '0);

  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      x_cnt     <= '0;
      y_cnt     <= '0;
      acc_cnt   <= '0;
      acc_min_x <= '1;
      acc_max_x <= '0;
      acc_min_y <= '1;
      acc_max_y <= '0;
`ifdef TRACKER_SUMS_EN
      acc_sum_x <= '0;
      acc_sum_y <= '0;
`endif
    end else begin
      if (!blank_q) x_cnt <= (x_use == '1) ? x_use : x_use + 1'b1;
      if (start_frame)  y_cnt <= '0;
      else if (eol)     y_cnt <= y_inc;
      if (start_frame) begin
        acc_cnt   <= '0;
        acc_min_x <= '1;
        acc_max_x <= '0;
        acc_min_y <= '1;
        acc_max_y <= '0;
`ifdef TRACKER_SUMS_EN
        acc_sum_x <= '0;
        acc_sum_y <= '0;
`endif
      end else begin
        acc_cnt   <= cnt_d;
        acc_min_x <= min_x_d;
        acc_max_x <= max_x_d;
        acc_min_y <= min_y_d;
        acc_max_y <= max_y_d;
`ifdef TRACKER_SUMS_EN
        acc_sum_x <= sum_x_d;
        acc_sum_y <= sum_y_d;
`endif
      end
    end
  end

  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      frame_valid <= 1'b0;
      found       <= 1'b0;
      min_x       <= '0;
      max_x       <= '0;
      min_y       <= '0;
      max_y       <= '0;
      match_count <= '0;
      sync_error  <= 1'b0;
      overrun     <= 1'b0;
`ifdef TRACKER_SUMS_EN
      sum_x       <= '0;
      sum_y       <= '0;
`endif
    end else begin
      if (publish) begin
        frame_valid <= 1'b1;
        found       <= any_d;
        match_count <= cnt_d;
        min_x       <= any_d ? min_x_d : '0;
        max_x       <= any_d ? max_x_d : '0;
        min_y       <= any_d ? min_y_d : '0;
        max_y       <= any_d ? max_y_d : '0;
`ifdef TRACKER_SUMS_EN
        sum_x       <= sum_x_d;
        sum_y       <= sum_y_d;
`endif
        // An ack landing with the publish consumed the old result.
        if (frame_valid && !frame_ack) overrun <= 1'b1;
      end else if (frame_ack) begin
        frame_valid <= 1'b0;
      end
      if ((state_q == ACCUM) && eol && (x_cnt != X_W'(H_ACTIVE)))
        sync_error <= 1'b1;
      if (publish && (y_chk != Y_W'(V_ACTIVE)))
        sync_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_color_tracker.sv
module tb_vga_color_tracker;

  localparam int          H    = 8;
  localparam int          V    = 4;
  localparam logic [23:0] RED  = 24'hFF_00_00;
  localparam logic [23:0] MASK = 24'hFF_FF_FF;

  logic        vclock = 1'b0;
  logic        reset, phsync, pvsync, pblank, frame_ack;
  logic [23:0] pixel;
  logic        frame_valid, found, sync_error, overrun;
  logic [10:0] min_x, max_x;
  logic [9:0]  min_y, max_y;
  logic [19:0] match_count;
`ifdef TRACKER_SUMS_EN
  logic [29:0] sum_x, sum_y;
`endif

  vga_color_tracker #(.H_ACTIVE(H), .V_ACTIVE(V), .MATCH_COLOR(RED), .MATCH_MASK(MASK)) dut (
    .vclock(vclock), .reset(reset), .phsync(phsync), .pvsync(pvsync), .pblank(pblank),
    .pixel(pixel), .frame_ack(frame_ack), .frame_valid(frame_valid), .found(found),
    .min_x(min_x), .max_x(max_x), .min_y(min_y), .max_y(max_y),
    .match_count(match_count), .sync_error(sync_error), .overrun(overrun)
`ifdef TRACKER_SUMS_EN
    , .sum_x(sum_x), .sum_y(sum_y)
`endif
  );

  always #5 vclock = ~vclock;

  int n_cmp = 0;
  int n_bad = 0;

  logic [23:0] img [0:V-1][0:H-1];
  int          line_len [0:V-1];

  int          e_cnt, e_minx, e_maxx, e_miny, e_maxy, e_sx, e_sy;
  logic        e_err;
  logic [62:0] exp_res;
  logic        fv2, fv3, ov3;

  function automatic logic [62:0] got_res();
    return {found, match_count, min_x, max_x, min_y, max_y};
  endfunction

  task automatic cyc();
    @(negedge vclock);
  endtask

  task automatic blank_cycles(input int n);
    pblank = 1'b1;
    pixel  = '0;
    repeat (n) cyc();
  endtask

  // Raster lines first..last, pixels from img, lengths from line_len.
  task automatic send_lines(input int first, input int last);
    for (int y = first; y <= last; y++) begin
      for (int x = 0; x < line_len[y]; x++) begin
        pblank = 1'b0;
        pixel  = img[y][x];
        cyc();
      end
      pblank = 1'b1;
      pixel  = '0;
      for (int i = 0; i < 6; i++) begin
        phsync = (i < 2 || i >= 4);
        cyc();
      end
      phsync = 1'b1;
    end
  endtask

  // Front porch, vsync pulse, back porch. Samples frame_valid 2 and 3 cycles
  // after pvsync falls at the port; optionally acks on the publish cycle.
  task automatic vsync_phase(input logic ack_at_pub, output logic v2, output logic v3,
                             output logic o3);
    blank_cycles(3);
    pvsync = 1'b0;
    cyc();
    cyc();
    v2 = frame_valid;
    frame_ack = ack_at_pub;
    cyc();
    v3 = frame_valid;
    o3 = overrun;
    frame_ack = 1'b0;
    repeat (3) cyc();
    pvsync = 1'b1;
    blank_cycles(4);
  endtask

  task automatic new_frame();
    logic [23:0] c;
    for (int y = 0; y < V; y++) begin
      line_len[y] = H;
      for (int x = 0; x < H; x++) begin
        c = 24'($urandom);
        if ((c & MASK) == (RED & MASK)) c = c ^ 24'h00_00_01;
        if ($urandom_range(0, 3) == 0) c = RED ^ (24'h1 << $urandom_range(0, 23));
        img[y][x] = c;
      end
    end
  endtask

  task automatic place(input int x, input int y);
    img[y][x] = RED;
  endtask

  // Reference: walk the frame as sent and collect the statistics directly.
  task automatic model_frame();
    e_cnt = 0; e_minx = 2047; e_maxx = 0; e_miny = 1023; e_maxy = 0;
    e_sx = 0; e_sy = 0; e_err = 1'b0;
    for (int y = 0; y < V; y++) begin
      if (line_len[y] != H) e_err = 1'b1;
      for (int x = 0; x < line_len[y]; x++) begin
        if ((img[y][x] & MASK) == (RED & MASK)) begin
          e_cnt++;
          e_sx += x;
          e_sy += y;
          if (x < e_minx) e_minx = x;
          if (x > e_maxx) e_maxx = x;
          if (y < e_miny) e_miny = y;
          if (y > e_maxy) e_maxy = y;
        end
      end
    end
    if (e_cnt == 0) begin
      e_minx = 0; e_maxx = 0; e_miny = 0; e_maxy = 0;
    end
    exp_res = {e_cnt != 0, 20'(e_cnt), 11'(e_minx), 11'(e_maxx), 10'(e_miny), 10'(e_maxy)};
  endtask

  task automatic test_reset();
    reset = 1'b1; phsync = 1'b1; pvsync = 1'b1; pblank = 1'b1; pixel = '0; frame_ack = 1'b0;
    cyc(); cyc();
    n_cmp++;
    if ({frame_valid, sync_error, overrun, got_res()} !== 66'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h required 0", {frame_valid, sync_error, overrun, got_res()});
    end
    reset = 1'b0;
    cyc(); cyc();
    n_cmp++;
    if ({frame_valid, sync_error, overrun, got_res()} !== 66'd0) begin
      n_bad++;
      $display("FAIL post_reset_outputs: got %h required 0", {frame_valid, sync_error, overrun, got_res()});
    end
  endtask

  task automatic test_first_frame();
    new_frame(); place(1, 1);
    send_lines(2, 3);
    vsync_phase(1'b0, fv2, fv3, ov3);
    n_cmp++;
    if (fv3 !== 1'b0) begin
      n_bad++; $display("FAIL discard_partial: frame_valid %b required 0", fv3);
    end
    new_frame(); place(2, 1); place(5, 1); place(3, 3);
    model_frame();
    send_lines(0, V-1);
    vsync_phase(1'b0, fv2, fv3, ov3);
    n_cmp++;
    if ({fv2, fv3} !== 2'b01) begin
      n_bad++; $display("FAIL valid_latency: fv@2=%b fv@3=%b required 0,1", fv2, fv3);
    end
    n_cmp++;
    if (got_res() !== exp_res) begin
      n_bad++; $display("FAIL first_frame_results: got %h required %h", got_res(), exp_res);
    end
    n_cmp++;
    if ({match_count, min_x, max_x, min_y, max_y} !== {20'd3, 11'd2, 11'd5, 10'd1, 10'd3}) begin
      n_bad++; $display("FAIL first_frame_literal: cnt=%0d x=%0d..%0d y=%0d..%0d", match_count, min_x, max_x, min_y, max_y);
    end
`ifdef TRACKER_SUMS_EN
    n_cmp++;
    if ({sum_x, sum_y} !== {30'd10, 30'd5}) begin
      n_bad++; $display("FAIL sums: sum_x=%0d sum_y=%0d required 10,5", sum_x, sum_y);
    end
`endif
    frame_ack = 1'b1; cyc(); frame_ack = 1'b0;
    n_cmp++;
    if (frame_valid !== 1'b0) begin
      n_bad++; $display("FAIL ack_drop: frame_valid %b required 0", frame_valid);
    end
    frame_ack = 1'b1; cyc(); frame_ack = 1'b0; cyc();
    n_cmp++;
    if ({frame_valid, overrun} !== 2'b00) begin
      n_bad++; $display("FAIL idle_ack: valid,overrun=%b required 00", {frame_valid, overrun});
    end
  endtask

  task automatic test_no_match();
    new_frame();
    model_frame();
    send_lines(0, V-1);
    vsync_phase(1'b0, fv2, fv3, ov3);
    n_cmp++;
    if ({fv3, got_res(), sync_error} !== {1'b1, exp_res, 1'b0}) begin
      n_bad++; $display("FAIL no_match: got v=%b %h err=%b required v=1 %h err=0", fv3, got_res(), sync_error, exp_res);
    end
    n_cmp++;
    if ({found, match_count} !== 21'd0) begin
      n_bad++; $display("FAIL no_match_found: found=%b cnt=%0d required 0", found, match_count);
    end
    frame_ack = 1'b1; cyc(); frame_ack = 1'b0;
  endtask

  task automatic test_random();
    for (int f = 0; f < 5; f++) begin
      new_frame();
      for (int k = $urandom_range(0, 6); k > 0; k--) place($urandom_range(0, H-1), $urandom_range(0, V-1));
      model_frame();
      send_lines(0, V-1);
      vsync_phase(1'b0, fv2, fv3, ov3);
      n_cmp++;
      if ({fv2, fv3, got_res()} !== {2'b01, exp_res}) begin
        n_bad++; $display("FAIL random_frame%0d: v=%b%b got %h required 01 %h", f, fv2, fv3, got_res(), exp_res);
      end
`ifdef TRACKER_SUMS_EN
      n_cmp++;
      if ({sum_x, sum_y} !== {30'(e_sx), 30'(e_sy)}) begin
        n_bad++; $display("FAIL random_sums%0d: got %0d,%0d required %0d,%0d", f, sum_x, sum_y, e_sx, e_sy);
      end
`endif
      frame_ack = 1'b1; cyc(); frame_ack = 1'b0;
      n_cmp++;
      if (frame_valid !== 1'b0) begin
        n_bad++; $display("FAIL random_ack%0d: frame_valid %b required 0", f, frame_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    new_frame(); place(0, 0);
    send_lines(0, V-1);
    vsync_phase(1'b0, fv2, fv3, ov3);
    new_frame(); place(7, 3); place(4, 2);
    model_frame();
    send_lines(0, V-1);
    vsync_phase(1'b1, fv2, fv3, ov3);
    n_cmp++;
    if ({fv2, fv3, ov3, frame_valid} !== 4'b1101) begin
      n_bad++; $display("FAIL ack_with_publish: v2,v3,ovr,v_after=%b required 1101", {fv2, fv3, ov3, frame_valid});
    end
    n_cmp++;
    if (got_res() !== exp_res) begin
      n_bad++; $display("FAIL ack_with_publish_results: got %h required %h", got_res(), exp_res);
    end
    new_frame(); place(6, 0);
    model_frame();
    send_lines(0, V-1);
    vsync_phase(1'b0, fv2, fv3, ov3);
    n_cmp++;
    if ({fv3, overrun, got_res()} !== {2'b11, exp_res}) begin
      n_bad++; $display("FAIL overrun: v=%b ovr=%b got %h required v=1 ovr=1 %h", fv3, overrun, got_res(), exp_res);
    end
    frame_ack = 1'b1; cyc(); frame_ack = 1'b0;
  endtask

  task automatic test_sync_error();
    n_cmp++;
    if (sync_error !== 1'b0) begin
      n_bad++; $display("FAIL sync_error_clean: got %b required 0", sync_error);
    end
    new_frame(); line_len[2] = 7; place(1, 2);
    model_frame();
    send_lines(0, V-1);
    vsync_phase(1'b0, fv2, fv3, ov3);
    n_cmp++;
    if ({fv3, sync_error, got_res()} !== {1'b1, e_err, exp_res}) begin
      n_bad++; $display("FAIL short_line: v=%b err=%b got %h required v=1 err=1 %h", fv3, sync_error, got_res(), exp_res);
    end
    frame_ack = 1'b1; cyc(); frame_ack = 1'b0;
    for (int f = 0; f < 2; f++) begin
      new_frame(); place(f, f);
      model_frame();
      send_lines(0, V-1);
      vsync_phase(1'b0, fv2, fv3, ov3);
      n_cmp++;
      if ({sync_error, got_res()} !== {1'b1, exp_res}) begin
        n_bad++; $display("FAIL sticky_error%0d: err=%b got %h required err=1 %h", f, sync_error, got_res(), exp_res);
      end
      frame_ack = 1'b1; cyc(); frame_ack = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    new_frame(); place(3, 0); place(2, 3);
    send_lines(0, V-1);
    vsync_phase(1'b0, fv2, fv3, ov3);
    new_frame(); place(1, 1);
    send_lines(0, 1);
    pblank = 1'b0; pixel = RED; cyc(); cyc();
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({frame_valid, sync_error, overrun, got_res()} !== 66'd0) begin
      n_bad++; $display("FAIL reset_mid_outputs: got %h required 0", {frame_valid, sync_error, overrun, got_res()});
    end
    pblank = 1'b1; pixel = '0;
    cyc(); cyc();
    reset = 1'b0;
    send_lines(2, V-1);
    vsync_phase(1'b0, fv2, fv3, ov3);
    n_cmp++;
    if (fv3 !== 1'b0) begin
      n_bad++; $display("FAIL reset_partial_pub: frame_valid %b required 0", fv3);
    end
    new_frame(); place(4, 2); place(7, 0); place(0, 3);
    model_frame();
    send_lines(0, V-1);
    vsync_phase(1'b0, fv2, fv3, ov3);
    n_cmp++;
    if ({fv3, sync_error, overrun, got_res()} !== {3'b100, exp_res}) begin
      n_bad++; $display("FAIL reset_next_full: v,err,ovr=%b got %h required 100 %h", {fv3, sync_error, overrun}, got_res(), exp_res);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_no_match();
    test_random();
    test_back_to_back();
    test_sync_error();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
